dtc_eval_collector: RTL and testbench

- Drive side and result side of a combinational decision-tree classifier: 12-bit feature vector in, 3-bit class out.
- Presents feature vectors to the classifier and samples its class output after a fixed latency.
- Accumulates a per-class histogram, a total count and a label-match count, readable through a register-select port.
- Two modes:
  - Exhaustive sweep: all 4096 inputs, self-generated.
  - Stream: labelled vectors delivered over a valid/ready interface.

---
 rtl/dtc_eval_collector.sv | 160 ++++++++++++++++
 tb/tb_dtc_eval_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_eval_collector.sv
// rtl/dtc_eval_collector.sv - drive/sample harness and class histogram for a combinational decision-tree classifier
module dtc_eval_collector #(
    parameter int CNT_W  = 16,
    parameter int DT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             clr,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [11:0]      s_feat,
    input  logic [2:0]       s_label,
    input  logic             s_last,
    output logic [11:0]      dt_inp,
    input  logic [2:0]       dt_outp,
    output logic             busy,
    output logic             done,
    output logic             sat,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data
);
    typedef enum logic [2:0] {S_IDLE, S_SWEEP, S_STREAM, S_DRAIN, S_DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [11:0]      idx_q, idx_d;
    logic [11:0]      dt_inp_q, dt_inp_d;
    logic [1:0]       drain_q, drain_d;
    logic             sweep_mode_q, sweep_mode_d;
    logic             sat_q, sat_d;
    logic [DT_LAT:0]  vld_q, vld_d;
    logic [2:0]       lbl_q [DT_LAT+1];
    logic [2:0]       lbl_d [DT_LAT+1];
    logic [CNT_W-1:0] cnt_q [10];   // 0-7 class counts, 8 total, 9 match
    logic [CNT_W-1:0] cnt_d [10];

    logic             idle_like;
    logic             issue;
    logic [2:0]       issue_lbl;
    logic             hit;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dt_inp_d     = dt_inp_q;
        drain_d      = drain_q;
        sweep_mode_d = sweep_mode_q;
        sat_d        = sat_q;
        cnt_d        = cnt_q;
        issue        = 1'b0;
        issue_lbl    = 3'd0;
        hit          = 1'b0;
        s_ready      = (state_q == S_STREAM);

        // idx_q is the next sweep vector; vector 0 is issued on the start edge itself
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sweep_mode_d = mode;
                    if (mode) begin
                        state_d  = S_SWEEP;
                        issue    = 1'b1;
                        dt_inp_d = 12'd0;
                        idx_d    = 12'd1;
                    end else begin
                        state_d  = S_STREAM;
                    end
                end
            end
            S_SWEEP: begin
                issue    = 1'b1;
                dt_inp_d = idx_q;
                if (idx_q == 12'hFFF) begin
                    state_d = S_DRAIN;
                    drain_d = 2'(DT_LAT);
                end else begin
                    idx_d = idx_q + 12'd1;
                end
            end
            S_STREAM: begin
                if (s_valid) begin
                    issue     = 1'b1;
                    issue_lbl = s_label;
                    dt_inp_d  = s_feat;
                    if (s_last) begin
                        state_d = S_DRAIN;
                        drain_d = 2'(DT_LAT);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) state_d = S_DONE;
                else                 drain_d = drain_q - 2'd1;
            end
            default: state_d = S_IDLE;
        endcase

        vld_d[0] = issue;
        lbl_d[0] = issue_lbl;
        for (int j = 1; j <= DT_LAT; j++) begin
            vld_d[j] = vld_q[j-1];
            lbl_d[j] = lbl_q[j-1];
        end

        if (vld_q[DT_LAT]) begin
            for (int k = 0; k < 10; k++) begin
                hit = (k == 8) || (k < 8 && dt_outp == 3'(k)) ||
                      (k == 9 && !sweep_mode_q && dt_outp == lbl_q[DT_LAT]);
                if (hit) begin
                    if (cnt_q[k] == CNT_MAX) sat_d = 1'b1;
                    else                     cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end

        // pipeline is empty in IDLE/DONE, so clearing cannot race a sample
        if (idle_like && (start || clr)) begin
            for (int k = 0; k < 10; k++) cnt_d[k] = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 12'd0;
            dt_inp_q     <= 12'd0;
            drain_q      <= 2'd0;
            sweep_mode_q <= 1'b0;
            sat_q        <= 1'b0;
            vld_q        <= '0;
            for (int j = 0; j <= DT_LAT; j++) lbl_q[j] <= 3'd0;
            for (int k = 0; k < 10; k++) cnt_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dt_inp_q     <= dt_inp_d;
            drain_q      <= drain_d;
            sweep_mode_q <= sweep_mode_d;
            sat_q        <= sat_d;
            vld_q        <= vld_d;
            lbl_q        <= lbl_d;
            cnt_q        <= cnt_d;
        end
    end

    assign dt_inp = dt_inp_q;
    assign busy   = (state_q == S_SWEEP) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign done   = (state_q == S_DONE);
    assign sat    = sat_q;

    always_comb begin
        rd_data = '0;
        if (rd_sel < 4'd10) rd_data = cnt_q[rd_sel];
    end
endmodule

// File: tb/tb_dtc_eval_collector.sv
// tb/tb_dtc_eval_collector.sv - directed and randomized checks of dtc_eval_collector against a run-level histogram model
`timescale 1ns/1ps
module tb_dtc_eval_collector;
    localparam int WA = 13;
    localparam int WB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, mode, clr, s_valid, s_last, stub_zero;
    logic [11:0]   s_feat;
    logic [2:0]    s_label;
    logic [3:0]    rd_sel;
    logic          s_ready_a, s_ready_b, busy_a, busy_b, done_a, done_b, sat_a, sat_b;
    logic [11:0]   dt_inp_a, dt_inp_b;
    logic [2:0]    dt_outp_a, dt_outp_b, stub_b1, stub_b2;
    logic [WA-1:0] rd_a;
    logic [WB-1:0] rd_b;

    assign dt_outp_a = stub_zero ? 3'd0 : dt_inp_a[2:0];
    always_ff @(posedge clk) begin
        stub_b1 <= stub_zero ? 3'd0 : dt_inp_b[2:0];
        stub_b2 <= stub_b1;
    end
    assign dt_outp_b = stub_b2;

    dtc_eval_collector #(.CNT_W(WA), .DT_LAT(0)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready_a), .s_feat(s_feat), .s_label(s_label), .s_last(s_last),
        .dt_inp(dt_inp_a), .dt_outp(dt_outp_a), .busy(busy_a), .done(done_a), .sat(sat_a),
        .rd_sel(rd_sel), .rd_data(rd_a));

    dtc_eval_collector #(.CNT_W(WB), .DT_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready_b), .s_feat(s_feat), .s_label(s_label), .s_last(s_last),
        .dt_inp(dt_inp_b), .dt_outp(dt_outp_b), .busy(busy_b), .done(done_b), .sat(sat_b),
        .rd_sel(rd_sel), .rd_data(rd_b));

    int     n_chk = 0, n_pass = 0, n_fail = 0;
    longint raw [10];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 10; k++) raw[k] = 0;
    endtask

    task automatic model_sample(input logic [11:0] feat, input logic [2:0] label, input bit is_stream);
        int cls;
        cls = stub_zero ? 0 : int'(feat[2:0]);
        raw[cls]++;
        raw[8]++;
        if (is_stream && cls == int'(label)) raw[9]++;
    endtask

    task automatic check_all(input string tag);
        bit over_a, over_b;
        longint e;
        over_a = 0;
        over_b = 0;
        for (int sel = 0; sel < 16; sel++) begin
            rd_sel = 4'(sel);
            @(negedge clk);
            e = (sel < 10) ? raw[sel] : 0;
            chk($sformatf("%s_a_sel%0d", tag, sel), 64'(rd_a), 64'(clamp(e, WA)));
            chk($sformatf("%s_b_sel%0d", tag, sel), 64'(rd_b), 64'(clamp(e, WB)));
            if (e > clamp(e, WA)) over_a = 1;
            if (e > clamp(e, WB)) over_b = 1;
        end
        chk({tag, "_sat_a"}, 64'(sat_a), 64'(over_a));
        chk({tag, "_sat_b"}, 64'(sat_b), 64'(over_b));
        step();
    endtask

    task automatic start_run(input bit m, input bit with_clr);
        start = 1'b1;
        mode  = m;
        clr   = with_clr;
        step();
        start = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic send(input logic [11:0] feat, input logic [2:0] label, input bit last, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) step();
        s_valid = 1'b1;
        s_feat  = feat;
        s_label = label;
        s_last  = last;
        n = 0;
        while (!s_ready_a && n < 50) begin
            step();
            n++;
        end
        if (!s_ready_a) chk("s_ready_timeout", 64'(s_ready_a), 64'd1);
        model_sample(feat, label, 1'b1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(done_a && done_b) && n < 200) begin
            step();
            n++;
        end
        if (!(done_a && done_b)) chk({tag, "_done_timeout"}, 64'({done_a, done_b}), 64'd3);
    endtask

    task automatic run_sweep(input string tag);
        int  c, da, db;
        bit  busy_gap;
        model_clear();
        for (int i = 0; i < 4096; i++) model_sample(12'(i), 3'd0, 1'b0);
        start_run(1'b1, 1'b0);
        c = 1;
        da = 0;
        db = 0;
        busy_gap = 0;
        chk({tag, "_first_vec"}, 64'(dt_inp_a), 64'd0);
        while ((da == 0 || db == 0) && c < 5000) begin
            if (done_a && da == 0) da = c;
            if (done_b && db == 0) db = c;
            if (c <= 4098 && !busy_b) busy_gap = 1;
            if (c == 4096) chk({tag, "_last_vec"}, 64'(dt_inp_a), 64'd4095);
            step();
            c++;
        end
        chk({tag, "_done_cycle_a"}, 64'(da), 64'd4097);
        chk({tag, "_done_cycle_b"}, 64'(db), 64'd4099);
        chk({tag, "_busy_b_1_4098"}, 64'(busy_gap), 64'd0);
        check_all(tag);
    endtask

    initial begin
        logic [11:0] dfeat [5];
        logic [2:0]  dlbl  [5];
        int          dgap  [5];
        logic [11:0] f;
        logic [2:0]  l;

        rst = 1'b1; start = 1'b0; mode = 1'b0; clr = 1'b0; stub_zero = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_feat = '0; s_label = '0; rd_sel = '0;
        repeat (3) step();
        chk("rst_dt_inp_a", 64'(dt_inp_a), 64'd0);
        chk("rst_dt_inp_b", 64'(dt_inp_b), 64'd0);
        chk("rst_flags_a", 64'({s_ready_a, busy_a, done_a, sat_a}), 64'd0);
        chk("rst_flags_b", 64'({s_ready_b, busy_b, done_b, sat_b}), 64'd0);
        model_clear();
        check_all("rst");
        rst = 1'b0;
        step();

        run_sweep("sweep");

        dfeat = '{12'h001, 12'h002, 12'h003, 12'h00F, 12'h7F0};
        dlbl  = '{3'd1, 3'd2, 3'd0, 3'd7, 3'd0};
        dgap  = '{0, 2, 1, 3, 0};
        model_clear();
        start_run(1'b0, 1'b0);
        chk("stream_ready_c1", 64'({s_ready_a, s_ready_b}), 64'd3);
        for (int i = 0; i < 5; i++) send(dfeat[i], dlbl[i], i == 4, dgap[i]);
        wait_done("dir");
        chk("dir_total_raw", 64'(raw[8]), 64'd5);
        chk("dir_match_raw", 64'(raw[9]), 64'd4);
        check_all("dir");

        model_clear();
        start_run(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            f = 12'($urandom);
            l = $urandom_range(0, 1) ? f[2:0] : 3'($urandom);
            if (i == 20) begin
                s_valid = 1'b0;
                start   = 1'b1;
                mode    = 1'b1;
                clr     = 1'b1;
                step();
                start = 1'b0;
                clr   = 1'b0;
                chk("busy_start_ignored", 64'({busy_a, s_ready_a, busy_b, s_ready_b}), 64'hF);
            end
            send(f, l, i == 39, $urandom_range(0, 3));
        end
        wait_done("rnd");
        check_all("rnd");

        stub_zero = 1'b1;
        model_clear();
        start_run(1'b0, 1'b0);
        for (int i = 0; i < 8195; i++) send(12'($urandom), 3'($urandom_range(0, 1)), i == 8194, 0);
        wait_done("satrun");
        check_all("satrun");

        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        check_all("clr_done");

        stub_zero = 1'b0;
        model_clear();
        start_run(1'b0, 1'b1);
        rd_sel = 4'd8;
        #1;
        chk("clrstart_busy", 64'({busy_a, busy_b}), 64'd3);
        for (int i = 0; i < 12; i++) send(12'($urandom), 3'($urandom), i == 11, $urandom_range(0, 2));
        wait_done("clrstart");
        check_all("clrstart");

        stub_zero = 1'b1;
        start_run(1'b1, 1'b0);
        repeat (99) step();
        rst = 1'b1;
        step();
        chk("midrst_dt_inp", 64'({dt_inp_a, dt_inp_b}), 64'd0);
        chk("midrst_flags", 64'({busy_a, done_a, busy_b, done_b}), 64'd0);
        model_clear();
        check_all("midrst");
        rst = 1'b0;
        step();
        run_sweep("sweep_zero");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
